// File: rtl/multicycle_abs_subtractor_pkg.sv
// Shared FSM encodings and mode constants for the multicycle subtractor.
// Pure declarations: no logic, no latency, no backpressure.
package msub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  localparam logic MODE_ABS    = 1'b0;
  localparam logic MODE_SIGNED = 1'b1;

endpackage

// File: rtl/multicycle_abs_subtractor_if.sv
// Start/busy/done request bus for the multicycle subtractor.
// Latency and backpressure are defined by the subtractor: start is ignored while busy.
interface multicycle_abs_subtractor_if #(
  parameter int WIDTH = 4
);
  localparam int OUT_W = 2 * WIDTH;

  logic             start;
  logic             mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [OUT_W-1:0] result;
  logic             neg;
  logic             zero;

  modport master (
    output start, mode, a, b,
    input  busy, done, result, neg, zero
  );

  modport slave (
    input  start, mode, a, b,
    output busy, done, result, neg, zero
  );

endinterface

// File: rtl/multicycle_abs_subtractor_slice.sv
// DIGIT-bit borrow-ripple subtractor slice: d = x - y - bin, bout = borrow out.
// Purely combinational, zero latency, no backpressure.
module sub_digit_slice #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] i_x,
  input  logic [DIGIT-1:0] i_y,
  input  logic             i_bin,
  output logic [DIGIT-1:0] o_d,
  output logic             o_bout
);

  logic w_borrow;

  always_comb begin
    w_borrow = i_bin;
    o_d      = '0;
    for (int i = 0; i < DIGIT; i++) begin
      o_d[i]   = i_x[i] ^ i_y[i] ^ w_borrow;
      w_borrow = (~i_x[i] & i_y[i]) | (~(i_x[i] ^ i_y[i]) & w_borrow);
    end
    o_bout = w_borrow;
  end

endmodule

// File: rtl/multicycle_abs_subtractor.sv
// Multicycle A-B, DIGIT bits per cycle; returns |A-B| or signed A-B with neg/zero flags.
// Latency N+2 cycles start-to-done; start is ignored (not queued) while busy.
module multicycle_abs_subtractor
  import msub_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DIGIT = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  multicycle_abs_subtractor_if.slave   bus
);

  localparam int N     = WIDTH / DIGIT;
  localparam int OUT_W = 2 * WIDTH;
  localparam int CW    = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  generate
    if (WIDTH < 2) begin : g_bad_width
      $error("multicycle_abs_subtractor: WIDTH must be >= 2");
    end
    if ((DIGIT < 1) || (WIDTH % DIGIT != 0)) begin : g_bad_digit
      $error("multicycle_abs_subtractor: DIGIT must divide WIDTH");
    end
  endgenerate

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_diff;
  logic             r_a_msb;
  logic             r_b_msb;
  logic             r_mode;
  logic             r_borrow;
  logic             r_busy;
  logic             r_done;
  logic             r_neg;
  logic             r_zero;
  logic [OUT_W-1:0] r_result;

  logic [DIGIT-1:0] w_d;
  logic             w_bout;
  logic [WIDTH-1:0] w_diff_next;
  logic             w_t;
  logic [WIDTH-1:0] w_mag;
  logic [OUT_W-1:0] w_fix_result;

  sub_digit_slice #(.DIGIT(DIGIT)) u_slice (
    .i_x    (r_a_sh[DIGIT-1:0]),
    .i_y    (r_b_sh[DIGIT-1:0]),
    .i_bin  (r_borrow),
    .o_d    (w_d),
    .o_bout (w_bout)
  );

  // Each new digit enters at the top, so after N shifts digit 0 sits at bit 0.
  assign w_diff_next = (r_diff >> DIGIT) | (WIDTH'(w_d) << (WIDTH - DIGIT));

  // Bit WIDTH of the extended subtraction: only the extension bits and the final borrow remain.
  always_comb begin
    w_t = ((r_mode == MODE_SIGNED) ? r_a_msb : 1'b0)
        ^ ((r_mode == MODE_SIGNED) ? r_b_msb : 1'b0)
        ^ r_borrow;
    w_mag = w_t ? (~r_diff + WIDTH'(1)) : r_diff;
    if (r_mode == MODE_SIGNED) begin
      w_fix_result = {{WIDTH{w_t}}, r_diff};
    end else begin
      w_fix_result = {{WIDTH{1'b0}}, w_mag};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_diff   <= '0;
      r_a_msb  <= 1'b0;
      r_b_msb  <= 1'b0;
      r_mode   <= MODE_ABS;
      r_borrow <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_neg    <= 1'b0;
      r_zero   <= 1'b0;
      r_result <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_a_sh   <= bus.a;
            r_b_sh   <= bus.b;
            r_a_msb  <= bus.a[WIDTH-1];
            r_b_msb  <= bus.b[WIDTH-1];
            r_mode   <= bus.mode;
            r_diff   <= '0;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
            r_state  <= CALC;
          end
        end
        CALC: begin
          r_a_sh   <= r_a_sh >> DIGIT;
          r_b_sh   <= r_b_sh >> DIGIT;
          r_diff   <= w_diff_next;
          r_borrow <= w_bout;
          if (r_cnt == LAST) begin
            r_cnt   <= '0;
            r_state <= FIX;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        FIX: begin
          r_result <= w_fix_result;
          r_neg    <= w_t;
          r_zero   <= (r_diff == '0) & ~w_t;
          r_done   <= 1'b1;
          r_busy   <= 1'b0;
          r_state  <= IDLE;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy   = r_busy;
  assign bus.done   = r_done;
  assign bus.result = r_result;
  assign bus.neg    = r_neg;
  assign bus.zero   = r_zero;

endmodule

// File: tb/tb_multicycle_abs_subtractor.sv
// Directed bench for multicycle_abs_subtractor: WIDTH=4/DIGIT=1 main instance, WIDTH=8/DIGIT=2 wide instance.
module tb_multicycle_abs_subtractor;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  multicycle_abs_subtractor_if #(.WIDTH(4)) bus ();
  multicycle_abs_subtractor_if #(.WIDTH(8)) bus8 ();

  multicycle_abs_subtractor #(.WIDTH(4), .DIGIT(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  multicycle_abs_subtractor #(.WIDTH(8), .DIGIT(2)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8)
  );

  // Drives one op starting in the current cycle (called at a negedge); returns at the
  // negedge of the done cycle. dcyc is the done cycle number relative to the start cycle.
  task automatic do_op(input logic m, input logic [3:0] av, input logic [3:0] bv,
                       input bit disturb, output int dcyc, output int busy_bad);
    dcyc     = -1;
    busy_bad = 0;
    bus.start = 1'b1;
    bus.mode  = m;
    bus.a     = av;
    bus.b     = bv;
    for (int c = 1; c <= 20 && dcyc < 0; c++) begin
      @(negedge clk);
      if (c == 1) bus.start = 1'b0;
      if (bus.done === 1'b1) dcyc = c;
      if (bus.busy !== ((c <= 5) ? 1'b1 : 1'b0)) busy_bad++;
      if (disturb && c == 2) begin
        bus.start = 1'b1;
        bus.mode  = ~m;
        bus.a     = ~av;
        bus.b     = ~bv;
      end
      if (disturb && c == 3) bus.start = 1'b0;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.start = 1'b0; bus.mode = 1'b0; bus.a = '0; bus.b = '0;
    bus8.start = 1'b0; bus8.mode = 1'b0; bus8.a = '0; bus8.b = '0;
    repeat (2) @(negedge clk);
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", bus.done); end
    total++; if (bus.result !== 8'h00) begin bad++; $display("FAIL reset_result: got %h want 00", bus.result); end
    total++; if ({bus.neg, bus.zero} !== 2'b00) begin bad++; $display("FAIL reset_flags: got %b want 00", {bus.neg, bus.zero}); end
    total++; if (bus8.result !== 16'h0000) begin bad++; $display("FAIL reset_result8: got %h want 0000", bus8.result); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic;
    int dcyc, bb, extra;
    do_op(1'b0, 4'd9, 4'd3, 1'b0, dcyc, bb);
    total++; if (dcyc !== 6) begin bad++; $display("FAIL t1_latency: got %0d want 6", dcyc); end
    total++; if (bb !== 0) begin bad++; $display("FAIL t1_busy: got %0d bad cycles want 0", bb); end
    total++; if (bus.result !== 8'h06) begin bad++; $display("FAIL t1_result: got %h want 06", bus.result); end
    total++; if ({bus.neg, bus.zero} !== 2'b00) begin bad++; $display("FAIL t1_flags: got %b want 00", {bus.neg, bus.zero}); end
    extra = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.done !== 1'b0) extra++;
    end
    total++; if (extra !== 0) begin bad++; $display("FAIL t1_single_done: got %0d extra want 0", extra); end
    total++; if (bus.result !== 8'h06) begin bad++; $display("FAIL t1_hold: got %h want 06", bus.result); end
  endtask

  task automatic test_abs;
    int dcyc, bb;
    do_op(1'b0, 4'd3, 4'd9, 1'b0, dcyc, bb);
    total++; if (bus.result !== 8'h06) begin bad++; $display("FAIL t2_result_a: got %h want 06", bus.result); end
    total++; if ({bus.neg, bus.zero} !== 2'b10) begin bad++; $display("FAIL t2_flags_a: got %b want 10", {bus.neg, bus.zero}); end
    @(negedge clk);
    do_op(1'b0, 4'd15, 4'd0, 1'b0, dcyc, bb);
    total++; if (bus.result !== 8'h0F) begin bad++; $display("FAIL t2_result_max: got %h want 0f", bus.result); end
    total++; if (bus.neg !== 1'b0) begin bad++; $display("FAIL t2_neg_max: got %b want 0", bus.neg); end
    total++; if (dcyc !== 6) begin bad++; $display("FAIL t2_latency: got %0d want 6", dcyc); end
  endtask

  task automatic test_signed;
    int dcyc, bb;
    do_op(1'b1, 4'h8, 4'h7, 1'b0, dcyc, bb);
    total++; if (bus.result !== 8'hF1) begin bad++; $display("FAIL t3_min_minus_max: got %h want f1", bus.result); end
    total++; if (bus.neg !== 1'b1) begin bad++; $display("FAIL t3_neg_a: got %b want 1", bus.neg); end
    @(negedge clk);
    do_op(1'b1, 4'h7, 4'h8, 1'b0, dcyc, bb);
    total++; if (bus.result !== 8'h0F) begin bad++; $display("FAIL t3_max_minus_min: got %h want 0f", bus.result); end
    total++; if (bus.neg !== 1'b0) begin bad++; $display("FAIL t3_neg_b: got %b want 0", bus.neg); end
    @(negedge clk);
    do_op(1'b1, 4'hD, 4'h2, 1'b0, dcyc, bb);
    total++; if (bus.result !== 8'hFB) begin bad++; $display("FAIL t3_m3_minus_2: got %h want fb", bus.result); end
    total++; if ({bus.neg, bus.zero} !== 2'b10) begin bad++; $display("FAIL t3_flags_c: got %b want 10", {bus.neg, bus.zero}); end
    total++; if (dcyc !== 6) begin bad++; $display("FAIL t3_latency: got %0d want 6", dcyc); end
  endtask

  task automatic test_back_to_back;
    int dcyc, bb;
    do_op(1'b0, 4'd5, 4'd5, 1'b0, dcyc, bb);
    total++; if (bus.result !== 8'h00) begin bad++; $display("FAIL t4_eq_result0: got %h want 00", bus.result); end
    total++; if ({bus.neg, bus.zero} !== 2'b01) begin bad++; $display("FAIL t4_eq_flags0: got %b want 01", {bus.neg, bus.zero}); end
    do_op(1'b1, 4'd5, 4'd5, 1'b0, dcyc, bb);
    total++; if (dcyc !== 6) begin bad++; $display("FAIL t4_b2b_latency: got %0d want 6", dcyc); end
    total++; if (bb !== 0) begin bad++; $display("FAIL t4_b2b_busy: got %0d bad cycles want 0", bb); end
    total++; if (bus.result !== 8'h00) begin bad++; $display("FAIL t4_eq_result1: got %h want 00", bus.result); end
    total++; if ({bus.neg, bus.zero} !== 2'b01) begin bad++; $display("FAIL t4_eq_flags1: got %b want 01", {bus.neg, bus.zero}); end
    @(negedge clk);
  endtask

  task automatic test_busy_ignore;
    int dcyc, bb, extra;
    do_op(1'b0, 4'd4, 4'd10, 1'b1, dcyc, bb);
    total++; if (dcyc !== 6) begin bad++; $display("FAIL t5_latency: got %0d want 6", dcyc); end
    total++; if (bus.result !== 8'h06) begin bad++; $display("FAIL t5_result: got %h want 06", bus.result); end
    total++; if (bus.neg !== 1'b1) begin bad++; $display("FAIL t5_neg: got %b want 1", bus.neg); end
    extra = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) extra++;
    end
    total++; if (extra !== 0) begin bad++; $display("FAIL t5_no_queue: got %0d active cycles want 0", extra); end
  endtask

  task automatic test_reset_mid;
    int dcyc, bb, seen;
    bus.start = 1'b1; bus.mode = 1'b0; bus.a = 4'd9; bus.b = 4'd3;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL t6_busy: got %b want 0", bus.busy); end
    total++; if (bus.result !== 8'h00) begin bad++; $display("FAIL t6_result: got %h want 00", bus.result); end
    total++; if ({bus.done, bus.neg, bus.zero} !== 3'b000) begin bad++; $display("FAIL t6_flags: got %b want 000", {bus.done, bus.neg, bus.zero}); end
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.done !== 1'b0) seen++;
    end
    rst = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) seen++;
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL t6_aborted_done: got %0d active cycles want 0", seen); end
    do_op(1'b0, 4'd12, 4'd5, 1'b0, dcyc, bb);
    total++; if (dcyc !== 6) begin bad++; $display("FAIL t6_after_latency: got %0d want 6", dcyc); end
    total++; if (bus.result !== 8'h07) begin bad++; $display("FAIL t6_after_result: got %h want 07", bus.result); end
    @(negedge clk);
  endtask

  task automatic test_wide;
    int dcyc;
    dcyc = -1;
    bus8.start = 1'b1; bus8.mode = 1'b0; bus8.a = 8'd200; bus8.b = 8'd55;
    for (int c = 1; c <= 20 && dcyc < 0; c++) begin
      @(negedge clk);
      if (c == 1) bus8.start = 1'b0;
      if (bus8.done === 1'b1) dcyc = c;
    end
    total++; if (dcyc !== 6) begin bad++; $display("FAIL w8_latency: got %0d want 6", dcyc); end
    total++; if (bus8.result !== 16'h0091) begin bad++; $display("FAIL w8_result: got %h want 0091", bus8.result); end
    total++; if ({bus8.neg, bus8.zero} !== 2'b00) begin bad++; $display("FAIL w8_flags: got %b want 00", {bus8.neg, bus8.zero}); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_abs();
    test_signed();
    test_back_to_back();
    test_busy_ignore();
    test_reset_mid();
    test_wide();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
